// File: rtl/alu_issue_queue.sv
// alu_issue_queue: out-of-order ALU reservation station.
//   Holds renamed ALU/branch/jump entries. Each entry tracks readiness of two
//   physical sources, and CDB broadcasts wake those sources. One ready entry
//   per cycle is issued, oldest first, into a registered issue slot.
//   Flush squashes the queue and the issue slot.
// Build option: define ALU_IQ_SPEC_WAKEUP_EN to add speculative wakeup. With
//   it, the phys_rd of a selected producer wakes dependents at the select edge.
// Ports:
//   clk, rst (sync, active-low), flush
//   disp_valid/disp_ready/disp_entry/disp_prs1/disp_prs2/disp_rs1_rdy/disp_rs2_rdy
//   cdb_valid/cdb_prd          - completion broadcast
//   iss_valid/iss_ready/iss_entry/iss_prs1/iss_prs2 - issue slot to PRF read
//   occupancy                  - number of valid queue slots (issue slot excluded)

package alu_iq_pkg;
    localparam int IQ_PREG_W = 6;

    typedef struct packed {
        logic [7:0]           rob_id;
        logic [3:0]           alu_op;
        logic                 regf_we;
        logic [IQ_PREG_W-1:0] phys_rd;
        logic [15:0]          imm;
    } reservation_station_entry_t;
endpackage

module alu_issue_queue
    import alu_iq_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int PREG_W = IQ_PREG_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  reservation_station_entry_t disp_entry,
    input  logic [PREG_W-1:0]          disp_prs1,
    input  logic [PREG_W-1:0]          disp_prs2,
    input  logic                       disp_rs1_rdy,
    input  logic                       disp_rs2_rdy,
    input  logic                       cdb_valid,
    input  logic [PREG_W-1:0]          cdb_prd,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output reservation_station_entry_t iss_entry,
    output logic [PREG_W-1:0]          iss_prs1,
    output logic [PREG_W-1:0]          iss_prs2,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;

    logic [DEPTH-1:0]           valid_q, valid_d;
    logic [DEPTH-1:0]           rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    reservation_station_entry_t entry_q [DEPTH];
    reservation_station_entry_t entry_d [DEPTH];
    logic [PREG_W-1:0]          prs1_q [DEPTH];
    logic [PREG_W-1:0]          prs1_d [DEPTH];
    logic [PREG_W-1:0]          prs2_q [DEPTH];
    logic [PREG_W-1:0]          prs2_d [DEPTH];
    // age_q[i][j] set: slot i was dispatched before slot j
    logic [DEPTH-1:0]           age_q [DEPTH];
    logic [DEPTH-1:0]           age_d [DEPTH];

    logic                       iss_valid_q, iss_valid_d;
    reservation_station_entry_t iss_entry_q, iss_entry_d;
    logic [PREG_W-1:0]          iss_prs1_q, iss_prs1_d, iss_prs2_q, iss_prs2_d;
    logic [OCC_W-1:0]           occ_q, occ_d;

    logic                       disp_fire, sel_fire, sel_en, older;
    logic [IDX_W-1:0]           free_idx, sel_idx;
    logic [DEPTH-1:0]           req;
    logic                       spec_valid;
    logic [PREG_W-1:0]          spec_tag;
    logic                       d_rdy1, d_rdy2;

    assign disp_ready = (occ_q < OCC_W'(DEPTH));
    assign occupancy  = occ_q;
    assign iss_valid  = iss_valid_q;
    assign iss_entry  = iss_entry_q;
    assign iss_prs1   = iss_prs1_q;
    assign iss_prs2   = iss_prs2_q;

    always_comb begin
        disp_fire = disp_valid && disp_ready && !flush;

        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end

        // Oldest ready slot: no other requesting slot is older than it.
        req     = valid_q & rdy1_q & rdy2_q;
        sel_en  = (!iss_valid_q || iss_ready) && !flush;
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            older = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                older = older | (req[j] & age_q[j][i]);
            end
            if (req[i] && !older) sel_idx = IDX_W'(i);
        end
        sel_fire = sel_en && (|req);

`ifdef ALU_IQ_SPEC_WAKEUP_EN
        spec_valid = sel_fire && entry_q[sel_idx].regf_we &&
                     (entry_q[sel_idx].phys_rd != '0);
        spec_tag   = PREG_W'(entry_q[sel_idx].phys_rd);
`else
        spec_valid = 1'b0;
        spec_tag   = '0;
`endif

        valid_d     = valid_q;
        rdy1_d      = rdy1_q;
        rdy2_d      = rdy2_q;
        entry_d     = entry_q;
        prs1_d      = prs1_q;
        prs2_d      = prs2_q;
        age_d       = age_q;
        iss_valid_d = iss_valid_q;
        iss_entry_d = iss_entry_q;
        iss_prs1_d  = iss_prs1_q;
        iss_prs2_d  = iss_prs2_q;
        occ_d       = occ_q + OCC_W'(disp_fire) - OCC_W'(sel_fire);

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && ((cdb_valid && cdb_prd == prs1_q[i]) ||
                               (spec_valid && spec_tag == prs1_q[i])))
                rdy1_d[i] = 1'b1;
            if (valid_q[i] && ((cdb_valid && cdb_prd == prs2_q[i]) ||
                               (spec_valid && spec_tag == prs2_q[i])))
                rdy2_d[i] = 1'b1;
        end

        if (sel_fire) begin
            valid_d[sel_idx] = 1'b0;
            iss_valid_d      = 1'b1;
            iss_entry_d      = entry_q[sel_idx];
            iss_prs1_d       = prs1_q[sel_idx];
            iss_prs2_d       = prs2_q[sel_idx];
        end else if (iss_ready) begin
            iss_valid_d = 1'b0;
        end

        d_rdy1 = disp_rs1_rdy || (disp_prs1 == '0) ||
                 (cdb_valid && cdb_prd == disp_prs1) ||
                 (spec_valid && spec_tag == disp_prs1);
        d_rdy2 = disp_rs2_rdy || (disp_prs2 == '0) ||
                 (cdb_valid && cdb_prd == disp_prs2) ||
                 (spec_valid && spec_tag == disp_prs2);

        // A free slot is never the selected one, so both can be written together.
        if (disp_fire) begin
            valid_d[free_idx] = 1'b1;
            entry_d[free_idx] = disp_entry;
            prs1_d[free_idx]  = disp_prs1;
            prs2_d[free_idx]  = disp_prs2;
            rdy1_d[free_idx]  = d_rdy1;
            rdy2_d[free_idx]  = d_rdy2;
            age_d[free_idx]   = '0;
            for (int j = 0; j < DEPTH; j++) begin
                if (IDX_W'(j) != free_idx) age_d[j][free_idx] = 1'b1;
            end
        end

        if (flush) begin
            valid_d     = '0;
            iss_valid_d = 1'b0;
            occ_d       = '0;
            for (int i = 0; i < DEPTH; i++) age_d[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q     <= '0;
            rdy1_q      <= '0;
            rdy2_q      <= '0;
            iss_valid_q <= 1'b0;
            iss_entry_q <= '0;
            iss_prs1_q  <= '0;
            iss_prs2_q  <= '0;
            occ_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
                prs1_q[i]  <= '0;
                prs2_q[i]  <= '0;
                age_q[i]   <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            rdy1_q      <= rdy1_d;
            rdy2_q      <= rdy2_d;
            entry_q     <= entry_d;
            prs1_q      <= prs1_d;
            prs2_q      <= prs2_d;
            age_q       <= age_d;
            iss_valid_q <= iss_valid_d;
            iss_entry_q <= iss_entry_d;
            iss_prs1_q  <= iss_prs1_d;
            iss_prs2_q  <= iss_prs2_d;
            occ_q       <= occ_d;
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;
    import alu_iq_pkg::*;

    logic clk = 1'b0;
    logic rst, flush, disp_valid, disp_ready, disp_rs1_rdy, disp_rs2_rdy;
    reservation_station_entry_t disp_entry, iss_entry;
    logic [5:0] disp_prs1, disp_prs2, cdb_prd, iss_prs1, iss_prs2;
    logic cdb_valid, iss_valid, iss_ready;
    logic [3:0] occupancy;

    int n_checks = 0;
    int n_pass   = 0;

    alu_issue_queue #(.DEPTH(8), .PREG_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_entry(disp_entry),
        .disp_prs1(disp_prs1), .disp_prs2(disp_prs2),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
        .cdb_valid(cdb_valid), .cdb_prd(cdb_prd),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_entry(iss_entry),
        .iss_prs1(iss_prs1), .iss_prs2(iss_prs2), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    function automatic reservation_station_entry_t mk(input logic [7:0] rob,
                                                      input logic we, input logic [5:0] rd);
        reservation_station_entry_t e;
        e.rob_id  = rob;
        e.alu_op  = rob[3:0];
        e.regf_we = we;
        e.phys_rd = rd;
        e.imm     = {8'hA5, rob};
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [7:0] rob, input logic [5:0] p1, input logic [5:0] p2,
                        input logic r1, input logic r2, input logic we, input logic [5:0] rd);
        disp_valid   = 1'b1;
        disp_entry   = mk(rob, we, rd);
        disp_prs1    = p1;
        disp_prs2    = p2;
        disp_rs1_rdy = r1;
        disp_rs2_rdy = r2;
    endtask

    task automatic cdb(input logic v, input logic [5:0] tag);
        cdb_valid = v;
        cdb_prd   = tag;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_entry = '0;
        disp_prs1 = '0; disp_prs2 = '0; disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0;
        cdb_valid = 1'b0; cdb_prd = '0; iss_ready = 1'b1;
        tick(); tick();
        check("rst_iss_valid", iss_valid, 0);
        check("rst_iss_entry", iss_entry, 0);
        check("rst_iss_prs1", iss_prs1, 0);
        check("rst_occ", occupancy, 0);
        check("rst_disp_ready", disp_ready, 1);
        rst = 1'b1;

        // Both sources ready at dispatch
        disp(8'd1, 6'd5, 6'd6, 1, 1, 0, 6'd0);
        tick(); disp_valid = 1'b0;
        check("a_occ_q", occupancy, 1);
        check("a_not_yet", iss_valid, 0);
        tick();
        check("a_iss_valid", iss_valid, 1);
        check("a_entry", iss_entry, mk(8'd1, 0, 6'd0));
        check("a_prs1", iss_prs1, 5);
        check("a_prs2", iss_prs2, 6);
        check("a_occ_0", occupancy, 0);
        tick();
        check("a_drain", iss_valid, 0);

        // Source woken by CDB two cycles after dispatch; prs2 is x0
        disp(8'd2, 6'd9, 6'd0, 0, 0, 0, 6'd0);
        tick(); disp_valid = 1'b0;
        check("b_occ", occupancy, 1);
        tick();
        check("b_wait", iss_valid, 0);
        cdb(1, 6'd9);
        tick(); cdb(0, 6'd0);
        check("b_not_before", iss_valid, 0);
        tick();
        check("b_issue", iss_entry.rob_id, 2);
        check("b_valid", iss_valid, 1);
        tick();
        check("b_drain", iss_valid, 0);

        // CDB matching a source in the dispatch cycle
        disp(8'd7, 6'd44, 6'd0, 0, 0, 0, 6'd0);
        cdb(1, 6'd44);
        tick(); disp_valid = 1'b0; cdb(0, 6'd0);
        tick();
        check("dcdb_issue", iss_entry.rob_id, 7);
        check("dcdb_valid", iss_valid, 1);
        tick();

        // Ordering: D overtakes unready C; then C (older) before E
        disp(8'd3, 6'd10, 6'd0, 0, 0, 0, 6'd0);
        tick();
        disp(8'd4, 6'd7, 6'd8, 1, 1, 0, 6'd0);
        tick(); disp_valid = 1'b0;
        check("cd_occ", occupancy, 2);
        tick();
        check("d_first", iss_entry.rob_id, 4);
        check("d_occ", occupancy, 1);
        disp(8'd5, 6'd3, 6'd4, 1, 1, 0, 6'd0);
        cdb(1, 6'd10);
        tick(); disp_valid = 1'b0; cdb(0, 6'd0);
        check("ce_gap", iss_valid, 0);
        check("ce_occ", occupancy, 2);
        tick();
        check("c_older", iss_entry.rob_id, 3);
        tick();
        check("e_next", iss_entry.rob_id, 5);
        check("e_occ", occupancy, 0);
        tick();

        // Fill to full, then free one slot
        for (int i = 0; i < 8; i++) begin
            disp(8'(10 + i), 6'(20 + i), 6'd0, 0, 0, 0, 6'd0);
            tick();
        end
        disp(8'd99, 6'd1, 6'd2, 1, 1, 0, 6'd0);
        check("full_occ", occupancy, 8);
        check("full_ready", disp_ready, 0);
        tick();
        check("full_drop", occupancy, 8);
        disp(8'd50, 6'd1, 6'd2, 1, 1, 0, 6'd0);
        cdb(1, 6'd23);
        tick(); cdb(0, 6'd0);
        check("full_pre_sel", disp_ready, 0);
        check("full_no_iss", iss_valid, 0);
        tick();
        check("full_sel", iss_entry.rob_id, 13);
        check("full_reopen", disp_ready, 1);
        check("full_occ7", occupancy, 7);
        tick(); disp_valid = 1'b0;
        check("refill_occ", occupancy, 8);
        check("refill_ready", disp_ready, 0);
        flush = 1'b1;
        tick(); flush = 1'b0;
        check("flush1_occ", occupancy, 0);
        check("flush1_ready", disp_ready, 1);

        // Issue slot held by iss_ready=0
        iss_ready = 1'b0;
        disp(8'd20, 6'd1, 6'd2, 1, 1, 0, 6'd0);
        tick();
        disp(8'd21, 6'd1, 6'd2, 1, 1, 0, 6'd0);
        tick();
        disp(8'd22, 6'd1, 6'd2, 1, 1, 0, 6'd0);
        tick(); disp_valid = 1'b0;
        check("hold_entry0", iss_entry.rob_id, 20);
        check("hold_occ0", occupancy, 2);
        tick(); tick();
        check("hold_entry", iss_entry, mk(8'd20, 0, 6'd0));
        check("hold_valid", iss_valid, 1);
        check("hold_occ", occupancy, 2);
        iss_ready = 1'b1;
        tick();
        check("rel_older", iss_entry.rob_id, 21);
        check("rel_occ", occupancy, 1);
        tick();
        check("rel_next", iss_entry.rob_id, 22);
        tick();
        check("rel_drain", iss_valid, 0);

        // Flush with simultaneous dispatch
        iss_ready = 1'b0;
        disp(8'd30, 6'd1, 6'd2, 1, 1, 0, 6'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            disp(8'(31 + k), 6'd40, 6'd0, 0, 0, 0, 6'd0);
            tick();
        end
        check("pre_flush_occ", occupancy, 5);
        check("pre_flush_iss", iss_valid, 1);
        check("pre_flush_ent", iss_entry.rob_id, 30);
        disp(8'd36, 6'd1, 6'd2, 1, 1, 0, 6'd0);
        flush = 1'b1;
        tick(); flush = 1'b0; disp_valid = 1'b0;
        check("flush_occ", occupancy, 0);
        check("flush_iss", iss_valid, 0);
        check("flush_ready", disp_ready, 1);
        iss_ready = 1'b1;
        cdb(1, 6'd40);
        tick(); cdb(0, 6'd0);
        tick(); tick();
        check("flush_dropped", iss_valid, 0);
        check("flush_occ_end", occupancy, 0);

        // Producer phys_rd=12 feeding a dependent on p12
        disp(8'd60, 6'd1, 6'd2, 1, 1, 1, 6'd12);
        tick();
        disp(8'd61, 6'd12, 6'd0, 0, 0, 0, 6'd0);
        tick(); disp_valid = 1'b0;
        check("prod_issue", iss_entry.rob_id, 60);
`ifdef ALU_IQ_SPEC_WAKEUP_EN
        tick();
        check("dep_b2b", iss_entry.rob_id, 61);
        check("dep_b2b_valid", iss_valid, 1);
        check("dep_occ", occupancy, 0);
`else
        tick();
        check("dep_wait", iss_valid, 0);
        check("dep_occ", occupancy, 1);
        cdb(1, 6'd12);
        tick(); cdb(0, 6'd0);
        check("dep_not_before", iss_valid, 0);
        tick();
        check("dep_issue", iss_entry.rob_id, 61);
`endif
        tick();
        check("dep_drain", iss_valid, 0);

        // Reset in the middle of operation
        disp(8'd70, 6'd1, 6'd2, 1, 1, 0, 6'd0);
        tick(); disp_valid = 1'b0;
        tick();
        check("mid_pre_iss", iss_valid, 1);
        rst = 1'b0;
        tick(); rst = 1'b1;
        check("mid_rst_iss", iss_valid, 0);
        check("mid_rst_occ", occupancy, 0);
        check("mid_rst_entry", iss_entry, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
